// File: rtl/strength_pkg.sv
// Shared types for the strength resolution monitor: resolved values,
// strength levels and the event record carried through the event FIFO.
package strength_pkg;

    typedef enum logic [1:0] {
        V0 = 2'd0,
        V1 = 2'd1,
        VZ = 2'd2,
        VX = 2'd3
    } val_e;

    localparam logic [2:0] ST_HIGHZ  = 3'd0;
    localparam logic [2:0] ST_SMALL  = 3'd1;
    localparam logic [2:0] ST_MEDIUM = 3'd2;
    localparam logic [2:0] ST_WEAK   = 3'd3;
    localparam logic [2:0] ST_LARGE  = 3'd4;
    localparam logic [2:0] ST_PULL   = 3'd5;
    localparam logic [2:0] ST_STRONG = 3'd6;
    localparam logic [2:0] ST_SUPPLY = 3'd7;

    // Channel field is sized for the largest supported channel count (16).
    typedef struct packed {
        logic [3:0] ch;
        val_e       val;
        logic [2:0] str;
    } evt_rec_t;

endpackage

// File: rtl/strength_ev_fifo.sv
// Synchronous event FIFO of DEPTH records; timestamp storage exists only
// when STRENGTH_MON_TSTAMP_EN is defined.
module strength_ev_fifo
    import strength_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TSW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  evt_rec_t       wr_rec,
`ifdef STRENGTH_MON_TSTAMP_EN
    input  logic [TSW-1:0] wr_tstamp,
    output logic [TSW-1:0] rd_tstamp,
`endif
    input  logic           pop,
    output evt_rec_t       rd_rec,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);

    evt_rec_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_rec;
    end

    assign rd_rec = empty ? evt_rec_t'('0) : mem[rd_ptr];

`ifdef STRENGTH_MON_TSTAMP_EN
    logic [TSW-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (do_push) ts_mem[wr_ptr] <= wr_tstamp;
    end

    assign rd_tstamp = empty ? '0 : ts_mem[rd_ptr];
`endif

endmodule

// File: rtl/strength_resolve_mon.sv
// Resolves multi-driver nets by strength, registers the result and queues
// change events. Define STRENGTH_MON_TSTAMP_EN to timestamp events.
module strength_resolve_mon
    import strength_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int NDRV  = 2,
    parameter int DEPTH = 8,
    parameter int TSW   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NCH*NDRV-1:0]                    drv_en,
    input  logic [NCH*NDRV-1:0]                    drv_val,
    input  logic [3*NCH*NDRV-1:0]                  drv_str,
    output logic [2*NCH-1:0]                       res_val,
    output logic [3*NCH-1:0]                       res_str,
    output logic                                   evt_valid,
    input  logic                                   evt_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] evt_ch,
    output logic [1:0]                             evt_val,
    output logic [2:0]                             evt_str,
    output logic [TSW-1:0]                         evt_tstamp,
    output logic [7:0]                             coalesce_cnt
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [4:0]     nxt [NCH];
    logic [NCH-1:0] change;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] push_sel;
    logic [NCH-1:0] push_mask;
    logic [NCH-1:0] merge;
    logic           found;
    logic [CHW-1:0] push_ch;
    logic [1:0]     push_val;
    logic [2:0]     push_str;
    logic [4:0]     merge_cnt;
    logic [8:0]     coal_sum;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    evt_rec_t       wr_rec;
    evt_rec_t       rd_rec;

    // Returns {value, strength}: only the strongest enabled drivers matter.
    function automatic logic [4:0] resolve_ch(input logic [NDRV-1:0]   en,
                                              input logic [NDRV-1:0]   val,
                                              input logic [3*NDRV-1:0] str);
        logic [2:0] m;
        logic       s0;
        logic       s1;
        m  = ST_HIGHZ;
        s0 = 1'b0;
        s1 = 1'b0;
        for (int d = 0; d < NDRV; d++) begin
            if (en[d] && (str[3*d +: 3] > m)) m = str[3*d +: 3];
        end
        for (int d = 0; d < NDRV; d++) begin
            if (en[d] && (str[3*d +: 3] == m)) begin
                if (val[d]) s1 = 1'b1;
                else        s0 = 1'b1;
            end
        end
        if (m == ST_HIGHZ)  return {VZ, ST_HIGHZ};
        else if (s0 && s1)  return {VX, m};
        else if (s1)        return {V1, m};
        else                return {V0, m};
    endfunction

    always_comb begin
        change   = '0;
        push_sel = '0;
        push_ch  = '0;
        push_val = VZ;
        push_str = ST_HIGHZ;
        found    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            nxt[c] = resolve_ch(drv_en[c*NDRV +: NDRV], drv_val[c*NDRV +: NDRV],
                                drv_str[3*c*NDRV +: 3*NDRV]);
            change[c] = (nxt[c] != {res_val[2*c +: 2], res_str[3*c +: 3]});
            if (!found && pend[c]) begin
                found       = 1'b1;
                push_sel[c] = 1'b1;
                push_ch     = CHW'(c);
                push_val    = res_val[2*c +: 2];
                push_str    = res_str[3*c +: 3];
            end
        end
    end

    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = found && (!fifo_full || pop);
    assign push_mask = push ? push_sel : '0;
    // A channel being pushed this cycle re-arms rather than coalesces.
    assign merge     = change & pend & ~push_mask;

    always_comb begin
        merge_cnt = '0;
        for (int c = 0; c < NCH; c++) merge_cnt = merge_cnt + {4'b0, merge[c]};
    end

    assign coal_sum = {1'b0, coalesce_cnt} + {4'b0, merge_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_val      <= {NCH{VZ}};
            res_str      <= '0;
            pend         <= '0;
            coalesce_cnt <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                res_val[2*c +: 2] <= nxt[c][4:3];
                res_str[3*c +: 3] <= nxt[c][2:0];
            end
            pend         <= (pend & ~push_mask) | change;
            coalesce_cnt <= coal_sum[8] ? 8'hFF : coal_sum[7:0];
        end
    end

    always_comb begin
        wr_rec     = '0;
        wr_rec.ch  = 4'(push_ch);
        wr_rec.val = val_e'(push_val);
        wr_rec.str = push_str;
    end

`ifdef STRENGTH_MON_TSTAMP_EN
    logic [TSW-1:0] tstamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tstamp <= '0;
        else     tstamp <= tstamp + 1'b1;
    end

    strength_ev_fifo #(.DEPTH(DEPTH), .TSW(TSW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wr_rec    (wr_rec),
        .wr_tstamp (tstamp),
        .rd_tstamp (evt_tstamp),
        .pop       (pop),
        .rd_rec    (rd_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    assign evt_tstamp = '0;

    strength_ev_fifo #(.DEPTH(DEPTH), .TSW(TSW)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_rec (wr_rec),
        .pop    (pop),
        .rd_rec (rd_rec),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
`endif

    assign evt_ch  = CHW'(rd_rec.ch);
    assign evt_val = rd_rec.val;
    assign evt_str = rd_rec.str;

endmodule

// File: tb/tb_strength_resolve_mon.sv
// Bench for strength_resolve_mon: directed scenarios plus a cycle-level
// reference model checked every cycle. Honours STRENGTH_MON_TSTAMP_EN.
module tb_strength_resolve_mon;

    localparam int NCH   = 4;
    localparam int NDRV  = 2;
    localparam int DEPTH = 8;
    localparam int TSW   = 16;
    localparam int CHW   = 2;
`ifdef STRENGTH_MON_TSTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct {
        int ch;
        int val;
        int str;
        int ts;
    } ev_t;

    logic                  clk;
    logic                  rst;
    logic [NCH*NDRV-1:0]   drv_en;
    logic [NCH*NDRV-1:0]   drv_val;
    logic [3*NCH*NDRV-1:0] drv_str;
    logic [2*NCH-1:0]      res_val;
    logic [3*NCH-1:0]      res_str;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [CHW-1:0]        evt_ch;
    logic [1:0]            evt_val;
    logic [2:0]            evt_str;
    logic [TSW-1:0]        evt_tstamp;
    logic [7:0]            coalesce_cnt;

    int  checks = 0;
    int  errors = 0;
    bit  check_en = 1'b0;

    int  mv [NCH] = '{default: 2};
    int  ms [NCH] = '{default: 0};
    bit  mp [NCH] = '{default: 1'b0};
    int  nv [NCH];
    int  ns [NCH];
    ev_t mq [$];
    int  mcoal = 0;
    int  mts = 0;

    strength_resolve_mon #(.NCH(NCH), .NDRV(NDRV), .DEPTH(DEPTH), .TSW(TSW)) dut (
        .clk          (clk),
        .rst          (rst),
        .drv_en       (drv_en),
        .drv_val      (drv_val),
        .drv_str      (drv_str),
        .res_val      (res_val),
        .res_str      (res_str),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_val      (evt_val),
        .evt_str      (evt_str),
        .evt_tstamp   (evt_tstamp),
        .coalesce_cnt (coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int c, input int d, input bit en,
                                 input bit val, input int str);
        int idx;
        idx = c * NDRV + d;
        drv_en[idx]          = en;
        drv_val[idx]         = val;
        drv_str[3*idx +: 3]  = 3'(str);
    endtask

    // Scan strength levels from strongest down; first populated level decides.
    function automatic void modelResolve(input int c, output int v, output int s);
        int n0;
        int n1;
        int idx;
        v = 2;
        s = 0;
        for (int lvl = 7; lvl >= 1; lvl--) begin
            n0 = 0;
            n1 = 0;
            for (int d = 0; d < NDRV; d++) begin
                idx = c * NDRV + d;
                if (drv_en[idx] && (int'(drv_str[3*idx +: 3]) == lvl)) begin
                    if (drv_val[idx]) n1++;
                    else              n0++;
                end
            end
            if (n0 + n1 > 0) begin
                s = lvl;
                v = (n0 > 0 && n1 > 0) ? 3 : ((n1 > 0) ? 1 : 0);
                return;
            end
        end
    endfunction

    // Reference model, advanced on every active clock edge or reset.
    initial forever begin
        int  pc;
        bit  mpop;
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                mv[c] = 2;
                ms[c] = 0;
                mp[c] = 1'b0;
            end
            mq.delete();
            mcoal = 0;
            mts   = 0;
        end else begin
            for (int c = 0; c < NCH; c++) modelResolve(c, nv[c], ns[c]);
            mpop = (mq.size() > 0) && evt_ready;
            pc = -1;
            if (mq.size() < DEPTH || mpop) begin
                for (int c = NCH - 1; c >= 0; c--) if (mp[c]) pc = c;
            end
            if (mpop) void'(mq.pop_front());
            if (pc >= 0) mq.push_back('{pc, mv[pc], ms[pc], mts});
            for (int c = 0; c < NCH; c++) begin
                bit changed;
                changed = (nv[c] != mv[c]) || (ns[c] != ms[c]);
                if (changed && mp[c] && c != pc && mcoal < 255) mcoal++;
                if (c == pc) mp[c] = 1'b0;
                if (changed) mp[c] = 1'b1;
                mv[c] = nv[c];
                ms[c] = ns[c];
            end
            mts = (mts + 1) % (1 << TSW);
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    initial forever begin
        logic [2*NCH-1:0] ev;
        logic [3*NCH-1:0] es;
        @(negedge clk);
        if (check_en && !rst) begin
            for (int c = 0; c < NCH; c++) begin
                ev[2*c +: 2] = 2'(mv[c]);
                es[3*c +: 3] = 3'(ms[c]);
            end
            checkOutput("model_res_val", 32'(res_val), 32'(ev));
            checkOutput("model_res_str", 32'(res_str), 32'(es));
            checkOutput("model_coalesce", 32'(coalesce_cnt), 32'(mcoal));
            checkOutput("model_evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                checkOutput("model_evt_ch", 32'(evt_ch), 32'(mq[0].ch));
                checkOutput("model_evt_val", 32'(evt_val), 32'(mq[0].val));
                checkOutput("model_evt_str", 32'(evt_str), 32'(mq[0].str));
                checkOutput("model_evt_tstamp", 32'(evt_tstamp), TS_EN ? 32'(mq[0].ts) : 32'd0);
            end
        end
    end

    initial begin
        int t3v [4] = '{2, 2, 0, 1};
        int t3s [4] = '{0, 0, 7, 2};
        int last_val [NCH];
        int last_str [NCH];
        logic [TSW-1:0] t0;

        rst       = 1'b1;
        drv_en    = '0;
        drv_val   = '0;
        drv_str   = '0;
        evt_ready = 1'b0;
        t0        = '0;
        for (int c = 0; c < NCH; c++) begin
            last_val[c] = -1;
            last_str[c] = -1;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_evt_valid", 32'(evt_valid), 32'd0);
        checkOutput("reset_res_val", 32'(res_val), 32'hAA);
        checkOutput("reset_res_str", 32'(res_str), 32'd0);
        checkOutput("reset_coalesce", 32'(coalesce_cnt), 32'd0);
        checkOutput("reset_payload", 32'({evt_ch, evt_val, evt_str, evt_tstamp}), 32'd0);

        // Single strong driver on channel 0
        rst = 1'b0;
        check_en = 1'b1;
        applyStimulus(0, 0, 1'b1, 1'b1, 6);
        @(negedge clk);
        checkOutput("t1_res_val", 32'(res_val[1:0]), 32'd1);
        checkOutput("t1_res_str", 32'(res_str[2:0]), 32'd6);
        checkOutput("t1_no_evt_yet", 32'(evt_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_evt_valid", 32'(evt_valid), 32'd1);
        checkOutput("t1_evt_ch", 32'(evt_ch), 32'd0);
        checkOutput("t1_evt_val", 32'(evt_val), 32'd1);
        checkOutput("t1_evt_str", 32'(evt_str), 32'd6);
        checkOutput("t1_evt_tstamp", 32'(evt_tstamp), TS_EN ? 32'd1 : 32'd0);
        evt_ready = 1'b1;
        @(negedge clk);
        checkOutput("t1_popped", 32'(evt_valid), 32'd0);

        // Weaker driver ignored, then equal-strength conflict gives X
        applyStimulus(1, 0, 1'b1, 1'b1, 6);
        applyStimulus(1, 1, 1'b1, 1'b0, 3);
        @(negedge clk);
        checkOutput("t2_res_val", 32'(res_val[3:2]), 32'd1);
        checkOutput("t2_res_str", 32'(res_str[5:3]), 32'd6);
        @(negedge clk);
        checkOutput("t2_evt_ch", 32'(evt_ch), 32'd1);
        checkOutput("t2_evt_val", 32'(evt_val), 32'd1);
        applyStimulus(1, 1, 1'b1, 1'b0, 6);
        @(negedge clk);
        checkOutput("t2_res_x", 32'(res_val[3:2]), 32'd3);
        @(negedge clk);
        checkOutput("t2_evt2_ch", 32'(evt_ch), 32'd1);
        checkOutput("t2_evt2_val", 32'(evt_val), 32'd3);
        checkOutput("t2_evt2_str", 32'(evt_str), 32'd6);
        @(negedge clk);

        // All four channels change together
        applyStimulus(0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1, 0, 1'b0, 1'b0, 0);
        applyStimulus(1, 1, 1'b0, 1'b0, 0);
        applyStimulus(2, 0, 1'b1, 1'b0, 7);
        applyStimulus(3, 1, 1'b1, 1'b1, 2);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) t0 = evt_tstamp;
            checkOutput("t3_evt_valid", 32'(evt_valid), 32'd1);
            checkOutput("t3_evt_ch", 32'(evt_ch), 32'(i));
            checkOutput("t3_evt_val", 32'(evt_val), 32'(t3v[i]));
            checkOutput("t3_evt_str", 32'(evt_str), 32'(t3s[i]));
            checkOutput("t3_evt_tstamp", 32'(evt_tstamp), TS_EN ? 32'(TSW'(t0 + TSW'(i))) : 32'd0);
        end

        // Overfill with ready low, then drain
        applyStimulus(2, 0, 1'b0, 1'b0, 0);
        applyStimulus(3, 1, 1'b0, 1'b0, 0);
        repeat (6) @(negedge clk);
        evt_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            applyStimulus(i % 2, 0, 1'b1, 1'b1, i / 2 + 1);
            @(negedge clk);
        end
        checkOutput("t4_valid_held", 32'(evt_valid), 32'd1);
        checkOutput("t4_coalesce", 32'(coalesce_cnt), 32'd1);
        evt_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (evt_valid) begin
                last_val[evt_ch] = int'(evt_val);
                last_str[evt_ch] = int'(evt_str);
            end
            @(negedge clk);
        end
        checkOutput("t4_drained", 32'(evt_valid), 32'd0);
        checkOutput("t4_ch0_final_val", 32'(last_val[0]), 32'd1);
        checkOutput("t4_ch0_final_str", 32'(last_str[0]), 32'd6);
        checkOutput("t4_ch1_final_str", 32'(last_str[1]), 32'd5);

        // Reset with queued events
        evt_ready = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0, 0);
        applyStimulus(1, 0, 1'b0, 1'b0, 0);
        applyStimulus(2, 0, 1'b1, 1'b0, 4);
        repeat (4) @(negedge clk);
        checkOutput("t5_queued", 32'(evt_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("t5_rst_res_val", 32'(res_val), 32'hAA);
        checkOutput("t5_rst_res_str", 32'(res_str), 32'd0);
        checkOutput("t5_rst_coalesce", 32'(coalesce_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_res_val", 32'(res_val[5:4]), 32'd0);
        checkOutput("t5_res_str", 32'(res_str[8:6]), 32'd4);
        @(negedge clk);
        checkOutput("t5_evt_valid", 32'(evt_valid), 32'd1);
        checkOutput("t5_evt_ch", 32'(evt_ch), 32'd2);
        checkOutput("t5_evt_val", 32'(evt_val), 32'd0);
        checkOutput("t5_evt_str", 32'(evt_str), 32'd4);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
